// File: rtl/fetch_pc_stage.sv
// Instruction-fetch PC stage: owns the PC and EPC registers and picks the
// next fetch address from sequential flow, stall hold, EX redirect,
// interrupt vectoring and eret return. It also produces the one-cycle IF/ID
// flush and the inting/ints tags that travel down the pipeline.
module fetch_pc_stage #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                VEC_BASE   = 'h200,
  parameter int                VEC_STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              eret,
  input  logic [2:0]        int_req,
  input  logic [2:0]        int_mask,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic [ADDR_W-1:0] epc,
  output logic              inting,
  output logic [2:0]        ints,
  output logic              if_flush_n
);

  localparam int N_INT = 3;

  // RUN: no handler active; SERVICE: handler running, nesting not allowed
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] epc_reg, epc_next;
  logic [N_INT-1:0]  pending_reg, pending_next;
  logic [N_INT-1:0]  int_req_reg;
  logic              halted_reg, halted_next;
  logic              inting_reg, inting_next;
  logic [N_INT-1:0]  ints_reg, ints_next;
  logic              flush_n_reg, flush_n_next;

  logic [N_INT-1:0]  int_rise;
  logic [N_INT-1:0]  int_ready;
  logic [N_INT-1:0]  int_lowest;
  logic [N_INT-1:0]  take_mask;
  logic [ADDR_W-1:0] vec_tbl  [N_INT];
  logic [ADDR_W-1:0] vec_term [N_INT];
  logic [ADDR_W-1:0] vec_sel;

  assign pc         = pc_reg;
  assign pc_4       = pc_reg + ADDR_W'(1);
  assign epc        = epc_reg;
  assign inting     = inting_reg;
  assign ints       = ints_reg;
  assign if_flush_n = flush_n_reg;

  // Rising edges against last cycle's sample; unmasked pending lines are candidates
  assign int_rise   = int_req & ~int_req_reg;
  assign int_ready  = pending_reg & ~int_mask;
  // Isolate the lowest set bit: line 0 has the highest priority
  assign int_lowest = int_ready & (~int_ready + 3'd1);

  // Per-line handler vectors, truncated to the PC width, gated by the winning line
  generate
    for (genvar gi = 0; gi < N_INT; gi++) begin : g_vec
      assign vec_tbl[gi]  = ADDR_W'(VEC_BASE + gi * VEC_STRIDE);
      assign vec_term[gi] = int_lowest[gi] ? vec_tbl[gi] : '0;
    end
  endgenerate

  // OR the gated vectors together; at most one term is non-zero
  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < N_INT; i++) begin
      vec_sel = vec_sel | vec_term[i];
    end
  end

  // Next-PC arbitration, FSM next state and the one-cycle pipeline tags
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    epc_next     = epc_reg;
    halted_next  = halted_reg;
    take_mask    = '0;
    inting_next  = 1'b0;
    ints_next    = '0;
    flush_n_next = 1'b1;

    if (en && !halted_reg) begin
      // halt takes effect from the following cycle; this cycle still arbitrates
      if (halt) begin
        halted_next = 1'b1;
      end
      if (eret && (state_reg == ST_SERVICE)) begin
        pc_next      = epc_reg;
        state_next   = ST_RUN;
        flush_n_next = 1'b0;
      end else if (redirect_en) begin
        pc_next      = redirect_pc;
        flush_n_next = 1'b0;
      end else if ((state_reg == ST_RUN) && !stall && (int_ready != '0)) begin
        epc_next     = pc_reg;
        pc_next      = vec_sel;
        take_mask    = int_lowest;
        inting_next  = 1'b1;
        ints_next    = int_lowest;
        flush_n_next = 1'b0;
        state_next   = ST_SERVICE;
      end else if (!stall) begin
        pc_next = pc_4;
      end
    end

    // Edge capture runs every cycle; a fresh edge re-arms a line taken this cycle
    pending_next = (pending_reg & ~take_mask) | int_rise;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      pc_reg      <= RESET_PC;
      epc_reg     <= '0;
      pending_reg <= '0;
      int_req_reg <= '0;
      halted_reg  <= 1'b0;
      inting_reg  <= 1'b0;
      ints_reg    <= '0;
      flush_n_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      epc_reg     <= epc_next;
      pending_reg <= pending_next;
      int_req_reg <= int_req;
      halted_reg  <= halted_next;
      inting_reg  <= inting_next;
      ints_reg    <= ints_next;
      flush_n_reg <= flush_n_next;
    end
  end

endmodule
